// File: rtl/pie_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pie_pkg
// Purpose  : Shared states, default PIE timing constants and RTcal helper.
// Revision : 1.0
// ============================================================================
package pie_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELIM = 3'd1,
        DATA0 = 3'd2,
        RTCAL = 3'd3,
        TRCAL = 3'd4,
        BITS  = 3'd5
    } pie_state_t;

    localparam int PIE_DATA0 = 20;
    localparam int PIE_DATA1 = 36;
    localparam int PIE_PW    = 10;
    localparam int PIE_DELIM = 42;

    function automatic logic [15:0] pie_rtcal(input logic [15:0] data0_len,
                                              input logic [15:0] data1_len);
        return data0_len + data1_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pie_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module   : pie_symbol_timer
// Purpose  : Sequences the high then low phase of one PIE symbol.
// Revision : 1.0
// ============================================================================
module pie_symbol_timer #(
    parameter int PW_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        low_only,
    input  logic [15:0] len,
    output logic        level,
    output logic        sym_end
);

    localparam logic [15:0] PW = 16'(PW_CYC);

    logic [15:0] cnt;

    // cnt holds the remaining cycles of the current phase minus one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b1;
            cnt   <= 16'd0;
        end else if (clear) begin
            level <= 1'b1;
            cnt   <= 16'd0;
        end else if (load) begin
            if (low_only) begin
                level <= 1'b0;
                cnt   <= len - 16'd1;
            end else if (len > PW) begin
                level <= 1'b1;
                cnt   <= len - PW - 16'd1;
            end else begin
                level <= 1'b0;
                cnt   <= PW - 16'd1;
            end
        end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end else if (level) begin
            level <= 1'b0;
            cnt   <= PW - 16'd1;
        end
    end

    assign sym_end = !level && (cnt == 16'd0);

endmodule
`default_nettype wire

// File: rtl/pie_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pie_encoder
// Purpose  : Gen2 reader PIE transmitter: delimiter, preamble, MSB-first bits.
// Revision : 1.0
// ============================================================================
module pie_encoder
    import pie_pkg::*;
#(
    parameter int DATA0_CYC = PIE_DATA0,
    parameter int DATA1_CYC = PIE_DATA1,
    parameter int PW_CYC    = PIE_PW,
    parameter int DELIM_CYC = PIE_DELIM
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        preamble,
    input  logic [15:0] trcal_cyc,
    input  logic [31:0] cmd_bits,
    input  logic [5:0]  cmd_len,
    output logic        pieout,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] D0_LEN    = 16'(DATA0_CYC);
    localparam logic [15:0] D1_LEN    = 16'(DATA1_CYC);
    localparam logic [15:0] DELIM_LEN = 16'(DELIM_CYC);

    pie_state_t  state, next_state;
    logic [31:0] shreg;
    logic [5:0]  bits_left;
    logic        pre_lat;
    logic [15:0] trcal_lat;

    logic        load, low_only, clear, latch, shift, done_next, sym_end;
    logic [15:0] sym_len;

    pie_symbol_timer #(.PW_CYC(PW_CYC)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .load     (load),
        .low_only (low_only),
        .len      (sym_len),
        .level    (pieout),
        .sym_end  (sym_end)
    );

    function automatic logic [15:0] bit_len(input logic b);
        return b ? D1_LEN : D0_LEN;
    endfunction

    always_comb begin
        next_state = state;
        load       = 1'b0;
        low_only   = 1'b0;
        sym_len    = 16'd0;
        latch      = 1'b0;
        shift      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = DELIM;
                    load       = 1'b1;
                    low_only   = 1'b1;
                    sym_len    = DELIM_LEN;
                    latch      = 1'b1;
                end
            end
            DELIM: if (sym_end) begin
                next_state = DATA0;
                load       = 1'b1;
                sym_len    = D0_LEN;
            end
            DATA0: if (sym_end) begin
                next_state = RTCAL;
                load       = 1'b1;
                sym_len    = pie_rtcal(D0_LEN, D1_LEN);
            end
            RTCAL, TRCAL: if (sym_end) begin
                if (state == RTCAL && pre_lat) begin
                    next_state = TRCAL;
                    load       = 1'b1;
                    sym_len    = trcal_lat;
                end else if (bits_left == 6'd0) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end else begin
                    next_state = BITS;
                    load       = 1'b1;
                    sym_len    = bit_len(shreg[31]);
                end
            end
            BITS: if (sym_end) begin
                shift = 1'b1;
                if (bits_left == 6'd1) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end else begin
                    // shreg shifts on this same edge, so the next bit is [30]
                    load    = 1'b1;
                    sym_len = bit_len(shreg[30]);
                end
            end
            default: next_state = IDLE;
        endcase

        if (abort && state != IDLE) begin
            next_state = IDLE;
            load       = 1'b0;
            shift      = 1'b0;
            done_next  = 1'b0;
        end
    end

    assign clear = (next_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            shreg     <= 32'd0;
            bits_left <= 6'd0;
            pre_lat   <= 1'b0;
            trcal_lat <= 16'd0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= done_next;
            if (latch) begin
                shreg     <= cmd_bits;
                bits_left <= (cmd_len > 6'd32) ? 6'd32 : cmd_len;
                pre_lat   <= preamble;
                trcal_lat <= trcal_cyc;
            end else if (shift) begin
                shreg     <= {shreg[30:0], 1'b0};
                bits_left <= bits_left - 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pie_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pie_encoder
// Purpose  : Self-checking bench for pie_encoder against a waveform model.
// Revision : 1.0
// ============================================================================
module tb_pie_encoder;

    localparam int D0    = 20;
    localparam int D1    = 36;
    localparam int PW    = 10;
    localparam int DELIM = 42;

    logic        clk = 1'b0;
    logic        reset, start, abort, preamble;
    logic [15:0] trcal_cyc;
    logic [31:0] cmd_bits;
    logic [5:0]  cmd_len;
    logic        pieout, busy, done;

    int total  = 0;
    int passed = 0;
    bit exp_q[$];
    bit glitch = 1'b0;
    bit hold   = 1'b0;

    pie_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .preamble  (preamble),
        .trcal_cyc (trcal_cyc),
        .cmd_bits  (cmd_bits),
        .cmd_len   (cmd_len),
        .pieout    (pieout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Expected pieout, one entry per cycle, derived from the symbol rules
    function automatic void push_sym(input int len);
        int h;
        h = (len > PW) ? len - PW : 0;
        repeat (h)  exp_q.push_back(1'b1);
        repeat (PW) exp_q.push_back(1'b0);
    endfunction

    function automatic void build(input bit pre, input int tr, input logic [31:0] bits, input int len);
        int n;
        exp_q.delete();
        repeat (DELIM) exp_q.push_back(1'b0);
        push_sym(D0);
        push_sym(D0 + D1);
        if (pre) push_sym(tr);
        n = (len > 32) ? 32 : len;
        for (int k = 0; k < n; k++) push_sym(bits[31-k] ? D1 : D0);
    endfunction

    task automatic send(input bit pre, input int tr, input logic [31:0] bits, input int len, input string tag);
        int errs;
        build(pre, tr, bits, len);
        @(negedge clk);
        preamble = pre; trcal_cyc = 16'(tr); cmd_bits = bits; cmd_len = 6'(len); start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        cmd_bits = $urandom; cmd_len = 6'($urandom); preamble = ~pre; trcal_cyc = 16'($urandom);
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (glitch && i == 50) start = 1'b1;
            if (glitch && i == 51) start = 1'b0;
            if (pieout !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) errs++;
            @(negedge clk);
        end
        chk({tag, " wave_err_cycles"}, errs, 0);
        chk({tag, " done"}, {31'd0, done}, 1);
        chk({tag, " cw_at_done"}, {31'd0, pieout}, 1);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 0);
        @(negedge clk);
        if (hold) begin
            chk({tag, " b2b_low"}, {31'd0, pieout}, 0);
            chk({tag, " b2b_busy"}, {31'd0, busy}, 1);
            start = 1'b0;
        end else begin
            chk({tag, " done_pulse"}, {31'd0, done}, 0);
        end
    endtask

    task automatic measure(input bit pre, input int tr, input logic [31:0] bits, input int len,
                           input int expv, input string tag);
        int cyc;
        @(negedge clk);
        preamble = pre; trcal_cyc = 16'(tr); cmd_bits = bits; cmd_len = 6'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, " frame_len"}, cyc, expv);
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; abort = 1'b0; preamble = 1'b0;
        trcal_cyc = 16'd0; cmd_bits = 32'd0; cmd_len = 6'd0;
        repeat (3) @(negedge clk);
        chk("reset_pieout", {31'd0, pieout}, 1);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        reset = 1'b0;

        measure(1'b0, 0, 32'h0000_0000, 4, 198, "queryrep");
        measure(1'b1, 112, 32'h8000_0000, 4, 326, "preamble");
        measure(1'b0, 0, 32'h0, 0, 118, "len0");
        send(1'b0, 0, 32'h0000_0000, 4, "queryrep_wave");
        send(1'b1, 112, 32'h8000_0000, 4, "preamble_wave");
        send(1'b1, 112, 32'h1234_5678, 0, "len0_wave");
        send(1'b0, 0, 32'hA5C3_0FF1, 40, "len40_wave");
        send(1'b1, 7, 32'hF000_000F, 6, "short_trcal");

        // start and abort together in IDLE: the start is dropped
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", {31'd0, busy}, 0);
        chk("abort_start_pieout", {31'd0, pieout}, 1);

        // abort during the second command bit
        @(negedge clk);
        preamble = 1'b0; cmd_bits = 32'hFFFF_0000; cmd_len = 6'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (DELIM + D0 + D0 + D1 + D1 + 5) @(negedge clk);
        chk("abort_pre_busy", {31'd0, busy}, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_pieout", {31'd0, pieout}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        seen = 0;
        repeat (400) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        send(1'b1, 64, 32'hDEAD_BEEF, 12, "after_abort");

        // asynchronous reset in the middle of TRcal
        @(negedge clk);
        preamble = 1'b1; trcal_cyc = 16'd112; cmd_bits = 32'h0; cmd_len = 6'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (DELIM + D0 + D0 + D1 + 30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_pieout", {31'd0, pieout}, 1);
        chk("areset_busy", {31'd0, busy}, 0);
        @(negedge clk); reset = 1'b0;

        glitch = 1'b1;
        send(1'b0, 0, 32'h5555_0000, 16, "start_while_busy");
        glitch = 1'b0;

        hold = 1'b1;
        send(1'b0, 0, 32'hC000_0000, 2, "back_to_back");
        hold = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("b2b_abort_busy", {31'd0, busy}, 0);

        for (int r = 0; r < 6; r++) begin
            bit          p;
            int          tr;
            logic [31:0] b;
            int          l;
            p  = 1'($urandom);
            tr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PW) : $urandom_range(PW + 1, 200);
            b  = $urandom;
            l  = $urandom_range(0, 40);
            send(p, tr, b, l, "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
